// File: rtl/apb_arb_pkg.sv
// Shared FSM state type and sizing helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // A disabled timeout (0) still gets a 1-bit counter so the vector is never empty.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin picker: first active request at or after the pointer wins;
// the pointer moves past the winner whenever a pick is taken.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic          found;
    logic [IW-1:0] k;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_q) + i) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
    valid_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among several requesters: round-robin pick,
// SETUP/ACCESS sequencing, wait-state hold and a per-transfer hang timeout.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = 32,
  parameter int REQUESTERS = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                                  PCLK,
  input  logic                                  PRESET,
  input  logic [REQUESTERS-1:0]                 req_i,
  input  logic [REQUESTERS-1:0][PADDR_SIZE-1:0] req_addr_i,
  input  logic [REQUESTERS-1:0]                 req_write_i,
  input  logic [REQUESTERS-1:0][PDATA_SIZE-1:0] req_wdata_i,
  output logic [REQUESTERS-1:0]                 req_gnt_o,
  output logic [REQUESTERS-1:0]                 req_done_o,
  output logic [PDATA_SIZE-1:0]                 req_rdata_o,
  output logic                                  req_err_o,
  output logic                                  PSEL,
  output logic                                  PENABLE,
  output logic [PADDR_SIZE-1:0]                 PADDR,
  output logic                                  PWRITE,
  output logic [PDATA_SIZE-1:0]                 PWDATA,
  input  logic [PDATA_SIZE-1:0]                 PRDATA,
  input  logic                                  PREADY,
  input  logic                                  PSLVERR
);

  localparam int            IW       = idx_width(REQUESTERS);
  localparam int            CW       = tmo_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e              state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [PADDR_SIZE-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic [REQUESTERS-1:0]   gnt_q, gnt_d;
  logic [REQUESTERS-1:0]   done_q, done_d;
  logic [PDATA_SIZE-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [REQUESTERS-1:0]   arb_req;
  logic [REQUESTERS-1:0]   arb_gnt;
  logic                    arb_valid;
  logic [IW-1:0]           arb_idx;
  logic                    timeout_hit;

  // A requester being told "done" this cycle still has req_i high; keep it out.
  assign arb_req = req_i & ~done_q;

  rr_arbiter #(
    .N (REQUESTERS)
  ) u_rr (
    .clk       (PCLK),
    .srst      (PRESET),
    .req_i     (arb_req),
    .advance_i (state_q == ST_IDLE),
    .gnt_o     (arb_gnt),
    .valid_o   (arb_valid),
    .idx_o     (arb_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          paddr_d  = req_addr_i[arb_idx];
          pwrite_d = req_write_i[arb_idx];
          pwdata_d = req_wdata_i[arb_idx];
          gnt_d    = arb_gnt;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (!PREADY && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A slave answering on the timeout cycle still gets its response through.
        if (PREADY || timeout_hit) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gnt_d     = '0;
          done_d    = gnt_q;
          err_d     = PREADY ? PSLVERR : 1'b1;
          rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign req_gnt_o   = gnt_q;
  assign req_done_o  = done_q;
  assign req_rdata_o = rdata_q;
  assign req_err_o   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter: a transaction-level model predicts
// service order, bus timing and responses; the bench also plays the APB slave.
module tb_apb_master_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int R  = 2;
  localparam int TO = 16;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic [R-1:0]         req_i;
  logic [R-1:0][AW-1:0] req_addr_i;
  logic [R-1:0]         req_write_i;
  logic [R-1:0][DW-1:0] req_wdata_i;
  logic [R-1:0]         req_gnt_o;
  logic [R-1:0]         req_done_o;
  logic [DW-1:0]        req_rdata_o;
  logic                 req_err_o;
  logic                 PSEL, PENABLE, PWRITE;
  logic [AW-1:0]        PADDR;
  logic [DW-1:0]        PWDATA;
  logic [DW-1:0]        PRDATA;
  logic                 PREADY, PSLVERR;

  apb_master_arbiter #(
    .PADDR_SIZE (AW),
    .PDATA_SIZE (DW),
    .REQUESTERS (R),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_gnt_o   (req_gnt_o),
    .req_done_o  (req_done_o),
    .req_rdata_o (req_rdata_o),
    .req_err_o   (req_err_o),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Requester-side drive values and per-requester transfer parameters.
  logic          d_req   [R];
  logic [AW-1:0] p_addr  [R];
  logic          p_write [R];
  logic [DW-1:0] p_wdata [R];
  logic [DW-1:0] p_prdata[R];
  logic          p_slverr[R];
  int            p_wait  [R];
  int            p_reps  [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_drive
    assign req_i[gi]       = d_req[gi];
    assign req_addr_i[gi]  = p_addr[gi];
    assign req_write_i[gi] = p_write[gi];
    assign req_wdata_i[gi] = p_wdata[gi];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rr       = 0;
  int n_xfer   = 0;
  int wt [7]   = '{0, 1, 2, 3, 15, 16, 40};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_params(input int i, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] wd, input int wait_cycles,
                            input logic [DW-1:0] rd, input logic se, input int reps);
    p_addr[i]   = a;
    p_write[i]  = w;
    p_wdata[i]  = wd;
    p_wait[i]   = wait_cycles;
    p_prdata[i] = rd;
    p_slverr[i] = se;
    p_reps[i]   = reps;
  endtask

  // Raise the requests in mask together while the bus is idle, then follow every
  // transfer the model predicts; each requester is served p_reps times.
  task automatic run_round(input logic [R-1:0] mask, input bit late_drop);
    bit            pend [R];
    int            left [R];
    int            npend, start, k, acc;
    bit            tmo, rdy;
    logic [R-1:0]  oh;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    @(negedge PCLK);
    npend = 0;
    for (int i = 0; i < R; i++) begin
      pend[i]  = ((mask >> i) & 1) != 0;
      left[i]  = p_reps[i];
      d_req[i] = pend[i];
      if (pend[i]) npend++;
    end
    start = int'(cyc);
    while (npend > 0) begin
      k = -1;
      for (int i = 0; i < R; i++) begin
        if (k < 0 && pend[(rr + i) % R]) k = (rr + i) % R;
      end
      rr      = (k + 1) % R;
      tmo     = (TO != 0) && (p_wait[k] >= TO);
      acc     = tmo ? TO : p_wait[k] + 1;
      exp_rd  = (tmo || p_write[k]) ? '0 : p_prdata[k];
      exp_err = tmo ? 1'b1 : p_slverr[k];
      oh      = R'(1) << k;
      for (int c = 1; c <= acc + 2; c++) begin
        @(negedge PCLK);
        check_eq("cycle_index", 128'(int'(cyc) - start), 128'(c));
        if (c == 1) begin
          check_eq("setup_ctl", {PSEL, PENABLE, req_gnt_o, req_done_o}, {1'b1, 1'b0, oh, {R{1'b0}}});
          check_eq("setup_bus", {PADDR, PWRITE, PWDATA}, {p_addr[k], p_write[k], p_wdata[k]});
        end else if (c <= acc + 1) begin
          check_eq("access_ctl", {PSEL, PENABLE, req_gnt_o, req_done_o}, {2'b11, oh, {R{1'b0}}});
          check_eq("access_bus", {PADDR, PWRITE, PWDATA}, {p_addr[k], p_write[k], p_wdata[k]});
          rdy     = (c - 2 == p_wait[k]);
          PREADY  = rdy;
          PRDATA  = rdy ? p_prdata[k] : $urandom;
          PSLVERR = rdy ? p_slverr[k] : 1'($urandom);
        end else begin
          check_eq("done_ctl", {PSEL, PENABLE, req_gnt_o, req_done_o}, {2'b00, {R{1'b0}}, oh});
          check_eq("done_rdata", req_rdata_o, exp_rd);
          check_eq("done_err", req_err_o, exp_err);
          PREADY = 1'b0;
        end
      end
      n_xfer++;
      $display("xfer %0d: req%0d %s addr=0x%03h wait=%0d rdata=0x%08h err=%0d at cycle %0d",
               n_xfer, k, p_write[k] ? "wr" : "rd", p_addr[k], p_wait[k], req_rdata_o, req_err_o, cyc);
      left[k]--;
      start = int'(cyc);
      if (left[k] == 0) begin
        pend[k] = 1'b0;
        npend--;
        if (late_drop) begin
          @(posedge PCLK);
          #1;
        end
        d_req[k] = 1'b0;
      end
    end
    @(negedge PCLK);
    check_eq("idle_after", {PSEL, PENABLE, req_gnt_o, req_done_o}, '0);
  endtask

  initial begin
    logic [R-1:0] m;
    int           reps;
    PRESET  = 1'b1;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    for (int i = 0; i < R; i++) begin
      d_req[i] = 1'b0;
      set_params(i, '0, 1'b0, '0, 0, '0, 1'b0, 1);
    end
    repeat (3) @(negedge PCLK);
    check_eq("reset_ctl", {PSEL, PENABLE, PWRITE, req_gnt_o, req_done_o, req_err_o}, '0);
    check_eq("reset_data", {PADDR, PWDATA, req_rdata_o}, '0);
    PRESET = 1'b0;

    // Zero-wait read, then a write with three wait states.
    set_params(0, 12'h040, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1);
    run_round(2'b01, 1'b0);
    set_params(1, 12'h104, 1'b1, 32'h12345678, 3, 32'hA5A5A5A5, 1'b0, 1);
    run_round(2'b10, 1'b0);

    // Contention: both held for two transfers each.
    set_params(0, 12'h010, 1'b0, 32'h0, 0, 32'h00000A0A, 1'b0, 2);
    set_params(1, 12'h020, 1'b1, 32'hCAFEF00D, 1, 32'h0, 1'b0, 2);
    run_round(2'b11, 1'b0);

    // Hung slave, then the same-cycle ready/timeout boundary.
    set_params(0, 12'h300, 1'b0, 32'h0, 40, 32'h77777777, 1'b0, 1);
    run_round(2'b01, 1'b0);
    set_params(1, 12'h304, 1'b0, 32'h0, 15, 32'h5151CAFE, 1'b0, 1);
    run_round(2'b10, 1'b0);

    // Slave error on a read, then a normal read; then a late requester drop.
    set_params(0, 12'h0F0, 1'b0, 32'h0, 1, 32'hBAD0BAD0, 1'b1, 1);
    run_round(2'b01, 1'b0);
    set_params(1, 12'h0F4, 1'b0, 32'h0, 0, 32'h600D600D, 1'b0, 1);
    run_round(2'b10, 1'b0);
    set_params(0, 12'h0F8, 1'b1, 32'h0BADCAFE, 2, 32'h0, 1'b0, 1);
    run_round(2'b01, 1'b1);

    // Reset during ACCESS while the pointer sits at 1.
    set_params(0, 12'h0A0, 1'b0, 32'h0, 0, 32'h11111111, 1'b0, 1);
    run_round(2'b01, 1'b0);
    @(negedge PCLK);
    d_req[0] = 1'b1;
    PREADY   = 1'b0;
    repeat (3) @(negedge PCLK);
    check_eq("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET   = 1'b0;
    d_req[0] = 1'b0;
    check_eq("reset_abort", {PSEL, PENABLE, req_gnt_o, req_done_o}, '0);
    repeat (3) begin
      @(negedge PCLK);
      check_eq("no_done_after_reset", {PSEL, req_done_o}, '0);
    end
    rr = 0;
    set_params(0, 12'h0B0, 1'b0, 32'h0, 0, 32'h22222222, 1'b0, 1);
    set_params(1, 12'h0B4, 1'b0, 32'h0, 0, 32'h33333333, 1'b0, 1);
    run_round(2'b11, 1'b0);

    for (int r = 0; r < 40; r++) begin
      m    = R'($urandom_range(1, 3));
      reps = (m == 2'b11) ? $urandom_range(1, 2) : 1;
      for (int i = 0; i < R; i++) begin
        set_params(i, AW'($urandom), 1'($urandom), $urandom, wt[$urandom_range(0, 6)],
                   $urandom, ($urandom_range(0, 3) == 0), reps);
      end
      run_round(m, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares the single APB master port that drives the slave decode mux among REQUESTERS independent bus requesters (CPU bridge, debug port, DMA).
- Round-robin arbitration; sequences the APB SETUP/ACCESS phases; holds through PREADY wait states.
- Returns read data and error to the granted requester.
- A per-transfer timeout ends a hung access with an error, so a dead slave cannot lock the bus.

Parameters:
- PADDR_SIZE, 12, APB address width.
- PDATA_SIZE, 32, APB data width.
- REQUESTERS, 2, number of requesters (>=1).
- TIMEOUT, 256, maximum ACCESS-phase cycles before forced error completion; 0 disables the timeout.

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  reset, synchronous, active-high.
- req_i  input  [REQUESTERS]  level request per requester; held until its done pulse.
- req_addr_i  input  [PADDR_SIZE] x [REQUESTERS]  transfer address.
- req_write_i  input  [REQUESTERS]  1=write, 0=read.
- req_wdata_i  input  [PDATA_SIZE] x [REQUESTERS]  write data.
- req_gnt_o  output  [REQUESTERS]  one-hot; high from SETUP through ACCESS completion of the owner's transfer.
- req_done_o  output  [REQUESTERS]  one-cycle completion pulse.
- req_rdata_o  output  PDATA_SIZE  read data, valid while any req_done_o is high; 0 for writes and timeouts.
- req_err_o  output  1  error flag, valid with req_done_o.
- PSEL  output  1  APB select to the mux.
- PENABLE  output  1  APB enable.
- PADDR  output  PADDR_SIZE  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  PDATA_SIZE  APB write data.
- PRDATA  input  PDATA_SIZE  muxed slave read data.
- PREADY  input  1  muxed slave ready.
- PSLVERR  input  1  muxed slave error.

Behaviour:
- Reset: synchronous, active-high, on PRESET=1 at a PCLK edge.
  - Outputs after reset: PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, req_rdata_o = 0; req_gnt_o, req_done_o, req_err_o = 0.
  - FSM goes to IDLE; round-robin pointer goes to 0; timeout counter goes to 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any unmasked req_i is high, select a winner with round-robin search starting at pointer.
  - Latch the winner's addr/write/wdata into PADDR/PWRITE/PWDATA; set that winner's gnt bit; go to SETUP.
  - Update pointer to winner+1, wrapping to 0 after REQUESTERS-1.
  - Mask: a requester whose req_done_o is high in this cycle is excluded from arbitration.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle; clear the timeout counter; go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA remain stable.
  - Timeout counter increments each cycle PREADY=0.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into registers; go to IDLE.
  - If TIMEOUT!=0, PREADY=0 and the counter equals TIMEOUT-1: complete with err=1 and rdata=0; go to IDLE.
  - If PREADY=1 and the timeout condition occur in the same cycle, PREADY wins and the slave response is used.
- Completion:
  - In the IDLE cycle after completion, req_done_o[owner]=1 for one cycle, with req_rdata_o and req_err_o valid. PSEL and PENABLE are 0 in that cycle.
  - req_gnt_o clears in that same cycle.
  - The requester must drop req_i by the following cycle; otherwise it is treated as a new request.
- Latency:
  - req_i rises in an IDLE cycle N: PSEL at N+1, PENABLE at N+2.
  - Zero-wait slave gives done at N+3. Each wait state adds one cycle.
  - Minimum turnaround is 3 cycles per transfer; no back-to-back ACCESS.
- Timeout counter: width clog2(TIMEOUT+1), saturating, never wraps.
- Between transfers, PADDR/PWRITE/PWDATA hold their last values.
- req_i deasserting while granted is ignored; the transfer completes normally.
- Reset in SETUP or ACCESS aborts the transfer: PSEL=0 after the edge and no done pulse.
- With REQUESTERS=1 the pointer is constant 0.

Decomposition:
- Package apb_arb_pkg holds:
  - the FSM state enum (IDLE, SETUP, ACCESS);
  - a localparam function for the counter width.
- One sub-module, rr_arbiter: combinational round-robin picker (request vector + pointer -> one-hot grant + valid) plus the registered pointer update.
- The FSM, latches and timeout counter stay in apb_master_arbiter.

Test Plan:
- Single read, zero wait: req0 addr 0x040, read; PREADY=1, PRDATA=0xDEADBEEF -> PSEL at N+1, PENABLE at N+2, done0 at N+3, rdata=0xDEADBEEF, err=0.
- Write with 3 wait states: req1 addr 0x104, wdata 0x12345678, PREADY low 3 cycles -> PENABLE high 4 cycles, PADDR/PWDATA stable throughout, done1 at N+6, rdata=0.
- Contention: req0 and req1 both held continuously after reset -> grant order 0,1,0,1; each done followed by an IDLE cycle; no requester starved.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> completion after the 16th ACCESS cycle with err=1, rdata=0; bus returns to IDLE.
- Slave error: PREADY=1 with PSLVERR=1 on a read -> done with err=1; the next request proceeds normally.
- Reset mid-ACCESS: PRESET=1 while PENABLE=1 -> next cycle PSEL=PENABLE=0, no done pulse, pointer=0, requester 0 wins the next arbitration.
